mm_job_sched: RTL and testbench

//  Job scheduler in front of the matrix-multiply engine. Queues matmul job

---
 rtl/mm_job_sched.sv | 147 ++++++++++++++
 tb/tb_mm_job_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mm_job_sched.sv
// mm_job_sched: job descriptor FIFO and dispatcher in front of the matmul engine.
// Issues one start pulse per job, watches tile progress, returns one completion per job.
module mm_job_sched #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int TILES    = 1024,
  parameter int CNT_W    = 11,
  parameter int TILE_TMO = 80,
  parameter int TMO_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_job_valid,
  output logic             o_job_ready,
  input  logic [1:0]       i_job_mode,
  input  logic [TAG_W-1:0] i_job_tag,
  output logic             o_mm_start,
  output logic [1:0]       o_mm_mode,
  input  logic             i_mm_tile_done,
  input  logic             i_mm_mtrx_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_tile_cnt,
  output logic             o_cpl_valid,
  input  logic             i_cpl_ready,
  output logic [TAG_W-1:0] o_cpl_tag,
  output logic             o_cpl_err,
  output logic             o_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = TAG_W + 2;

  typedef enum logic [1:0] {IDLE, START, RUN, HALT} state_t;
  state_t state_q, state_d;

  logic [ENT_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             fifo_empty, push, pop;

  logic [TAG_W-1:0] tag_q;
  logic [TMO_W-1:0] wd_q;
  logic [CNT_W-1:0] cnt_inc, final_cnt;
  logic             dispatch, cpl_load, timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign fifo_empty  = (fifo_cnt == '0);
  assign o_job_ready = (fifo_cnt != (PTR_W+1)'(DEPTH));
  assign push        = i_job_valid & o_job_ready;
  assign pop         = dispatch;
  assign o_busy      = (state_q != IDLE);
  assign cnt_inc     = sat_inc(o_tile_cnt);
  // A tile_done coinciding with mtrx_done is part of the final count.
  assign final_cnt   = i_mm_tile_done ? cnt_inc : o_tile_cnt;

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= {i_job_mode, i_job_tag};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dispatch = 1'b0;
    cpl_load = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Dispatch only when the completion slot is free by the time this job can finish.
        if (!fifo_empty && !o_err && (!o_cpl_valid || i_cpl_ready)) begin
          dispatch = 1'b1;
          state_d  = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (i_mm_mtrx_done) begin
          cpl_load = 1'b1;
          state_d  = IDLE;
        end else if (!i_mm_tile_done && wd_q == TMO_W'(TILE_TMO - 1)) begin
          timeout  = 1'b1;
          cpl_load = 1'b1;
          state_d  = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mm_start  <= 1'b0;
      o_mm_mode   <= '0;
      tag_q       <= '0;
      o_tile_cnt  <= '0;
      wd_q        <= '0;
      o_cpl_valid <= 1'b0;
      o_cpl_tag   <= '0;
      o_cpl_err   <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_mm_start <= dispatch;
      if (dispatch) begin
        {o_mm_mode, tag_q} <= fifo_mem[rd_ptr];
        o_tile_cnt         <= '0;
        wd_q               <= '0;
      end else if (state_q == RUN) begin
        if (i_mm_tile_done) begin
          o_tile_cnt <= cnt_inc;
          wd_q       <= '0;
        end else begin
          wd_q <= wd_q + TMO_W'(1);
        end
      end
      if (cpl_load) begin
        o_cpl_valid <= 1'b1;
        o_cpl_tag   <= tag_q;
        o_cpl_err   <= timeout | (final_cnt != CNT_W'(TILES));
      end else if (i_cpl_ready) begin
        o_cpl_valid <= 1'b0;
      end
      if (timeout) o_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mm_job_sched.sv
// tb_mm_job_sched: randomized bench with a transaction-level job/engine model
// for mm_job_sched (ordering, completion contents, watchdog timing, reset).
module tb_mm_job_sched;
  localparam int DEPTH = 4, TAG_W = 4, TILES = 1024, CNT_W = 11, TILE_TMO = 80, TMO_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic job_valid, job_ready, mm_start, tile_done, mtrx_done, busy;
  logic cpl_valid, cpl_ready, cpl_err, err;
  logic [1:0] job_mode, mm_mode;
  logic [TAG_W-1:0] job_tag, cpl_tag;
  logic [CNT_W-1:0] tile_cnt;

  always #5 clk = ~clk;

  mm_job_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TILES(TILES), .CNT_W(CNT_W),
                 .TILE_TMO(TILE_TMO), .TMO_W(TMO_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_job_valid(job_valid), .o_job_ready(job_ready),
    .i_job_mode(job_mode), .i_job_tag(job_tag), .o_mm_start(mm_start), .o_mm_mode(mm_mode),
    .i_mm_tile_done(tile_done), .i_mm_mtrx_done(mtrx_done), .o_busy(busy),
    .o_tile_cnt(tile_cnt), .o_cpl_valid(cpl_valid), .i_cpl_ready(cpl_ready),
    .o_cpl_tag(cpl_tag), .o_cpl_err(cpl_err), .o_err(err));

  // One job: descriptor plus how the engine model behaves for it.
  typedef struct {
    logic [1:0] mode; logic [TAG_W-1:0] tag;
    int tiles; bit stall; int gap; bit sep;
  } job_t;

  job_t src_q[$], pend_q[$], cpl_q[$];
  int total = 0, bad = 0, cyc = 0;
  int push_pct = 100, rdy_pct = 100, noise_pct = 0, gap_max = 1;
  int n_start = 0, push_cyc = 0, start_cyc = 0, tmo_cyc = 0;
  int eng_left = 0, eng_gap = 0, eng_fix = -1, eng_last = 0;
  bit eng_on = 0, eng_stall = 0, eng_sep = 0, stall_live = 0;
  logic [1:0] cur_mode = 2'd0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic job_t mk(int mode, int tag, int tiles, bit stall, int gap, bit sep);
    job_t j;
    j.mode = 2'(mode); j.tag = TAG_W'(tag); j.tiles = tiles;
    j.stall = stall; j.gap = gap; j.sep = sep;
    return j;
  endfunction

  function automatic int next_gap();
    if (eng_fix >= 0) return eng_fix;
    return int'($urandom_range(gap_max, 0));
  endfunction

  task automatic check_reset_vals(string tag);
    check_eq({tag, "_outs"}, 32'({mm_start, mm_mode, busy, cpl_valid, cpl_err, err, cpl_tag, tile_cnt}), 32'd0);
    check_eq({tag, "_ready"}, 32'(job_ready), 32'd1);
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0; job_valid = 1'b0; tile_done = 1'b0; mtrx_done = 1'b0; cpl_ready = 1'b0;
    #1;
    check_reset_vals(tag);
    src_q.delete(); pend_q.delete(); cpl_q.delete();
    eng_on = 0; eng_left = 0; stall_live = 0; tmo_cyc = 0; cur_mode = 2'd0;
    repeat (2) @(negedge clk);
    check_reset_vals({tag, "_hold"});
    rst_n = 1'b1;
  endtask

  // One clock: sample outputs at negedge, check against the model, drive next inputs.
  task automatic step();
    job_t j;
    @(negedge clk);
    cyc++;
    cpl_ready = (int'($urandom_range(99, 0)) < rdy_pct);
    if (mm_start) begin
      n_start++; start_cyc = cyc;
      check_eq("start_not_halted", 32'(stall_live), 32'd0);
      check_eq("start_cpl_free", 32'(cpl_valid), 32'd0);
      check_eq("start_has_job", 32'(pend_q.size() > 0), 32'd1);
      if (pend_q.size() > 0) begin
        j = pend_q.pop_front();
        cur_mode = j.mode;
        cpl_q.push_back(j);
        eng_on = 1; eng_left = j.tiles; eng_stall = j.stall; eng_sep = j.sep;
        eng_fix = j.gap; eng_gap = next_gap(); eng_last = cyc; stall_live = j.stall;
      end
    end
    check_eq("mm_mode", 32'(mm_mode), 32'(cur_mode));
    if (cpl_valid) begin
      check_eq("cpl_expected", 32'(cpl_q.size() > 0), 32'd1);
      if (cpl_q.size() > 0) begin
        check_eq("cpl_tag", 32'(cpl_tag), 32'(cpl_q[0].tag));
        check_eq("cpl_err", 32'(cpl_err), 32'(cpl_q[0].stall || cpl_q[0].tiles != TILES));
        check_eq("cpl_cnt", 32'(tile_cnt), 32'(cpl_q[0].tiles > CNT_MAX ? CNT_MAX : cpl_q[0].tiles));
        if (cpl_ready) void'(cpl_q.pop_front());
      end
    end
    check_eq("err_flag", 32'(err), 32'(tmo_cyc != 0 && cyc >= tmo_cyc));
    if (tmo_cyc != 0 && cyc == tmo_cyc - 1) check_eq("tmo_early", 32'(cpl_valid), 32'd0);
    if (tmo_cyc != 0 && cyc == tmo_cyc)     check_eq("tmo_cpl", 32'(cpl_valid), 32'd1);
    check_eq("job_ready", 32'(job_ready), 32'(pend_q.size() < DEPTH));
    tile_done = 1'b0; mtrx_done = 1'b0;
    if (eng_on && !mm_start) begin
      if (eng_gap > 0) eng_gap--;
      else if (eng_left > 0) begin
        tile_done = 1'b1; eng_left--; eng_last = cyc; eng_gap = next_gap();
        if (eng_left == 0 && !eng_stall && !eng_sep) begin mtrx_done = 1'b1; eng_on = 0; end
      end else if (!eng_stall) begin
        mtrx_done = 1'b1; eng_on = 0;
      end
      // Stalled engine: watchdog expires TILE_TMO quiet RUN cycles after the last event.
      if (eng_on && eng_stall && eng_left == 0) begin
        eng_on = 0; tmo_cyc = eng_last + TILE_TMO + 1;
      end
    end else if (!eng_on && !stall_live && !mm_start && int'($urandom_range(99, 0)) < noise_pct) begin
      tile_done = 1'($urandom); mtrx_done = 1'($urandom);
    end
    job_valid = 1'b0; job_mode = 2'($urandom); job_tag = TAG_W'($urandom);
    if (src_q.size() > 0 && int'($urandom_range(99, 0)) < push_pct) begin
      job_valid = 1'b1; job_mode = src_q[0].mode; job_tag = src_q[0].tag;
      if (job_ready) begin pend_q.push_back(src_q.pop_front()); push_cyc = cyc; end
    end
  endtask

  task automatic run_drain(int budget, string tag);
    int n = 0;
    while ((src_q.size() > 0 || pend_q.size() > 0 || cpl_q.size() > 0 || eng_on) && n < budget) begin
      step(); n++;
    end
    check_eq(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n, n0, r, t;
    job_valid = 1'b0; job_mode = '0; job_tag = '0;
    tile_done = 1'b0; mtrx_done = 1'b0; cpl_ready = 1'b0;
    @(negedge clk);
    do_reset("reset");

    // Single INT4_VSQ job, full tile count.
    gap_max = 2;
    src_q.push_back(mk(2, 5, TILES, 0, -1, 0));
    run_drain(8000, "t1_drain");
    check_eq("t1_latency", 32'(start_cyc - push_cyc), 32'd2);
    check_eq("t1_cnt", 32'(tile_cnt), 32'(TILES));
    check_eq("t1_starts", 32'(n_start), 32'd1);

    // Six jobs with completions blocked: FIFO fills, job1 waits on cpl0.
    n0 = n_start; rdy_pct = 0; gap_max = 0;
    for (int i = 0; i < 6; i++) src_q.push_back(mk(i % 3, i, (i == 0) ? TILES : 3 * i, 0, 0, 0));
    n = 0;
    while (!(cpl_valid && src_q.size() == 1) && n < 3000) begin step(); n++; end
    check_eq("t2_cpl0_wait", 32'(n < 3000), 32'd1);
    repeat (40) step();
    check_eq("t2_one_start", 32'(n_start - n0), 32'd1);
    check_eq("t2_full", 32'(job_ready), 32'd0);
    check_eq("t2_held", 32'(src_q.size()), 32'd1);
    rdy_pct = 100;
    run_drain(3000, "t2_drain");
    check_eq("t2_all_started", 32'(n_start - n0), 32'd6);

    // Count mismatches, watchdog just short of expiry, and counter saturation.
    n0 = n_start; gap_max = 1;
    src_q.push_back(mk(0, 3, TILES - 1, 0, 0, 0));
    src_q.push_back(mk(1, 4, TILES, 0, 0, 1));
    src_q.push_back(mk(2, 6, 2, 0, TILE_TMO - 1, 1));
    src_q.push_back(mk(3, 7, TILES + 1, 0, 0, 0));
    src_q.push_back(mk(1, 8, CNT_MAX + 53, 0, 0, 0));
    run_drain(12000, "t3_drain");
    check_eq("t3_next_ran", 32'(n_start - n0), 32'd5);
    check_eq("t3_sat", 32'(tile_cnt), 32'(CNT_MAX));
    check_eq("t3_no_err", 32'(err), 32'd0);

    // Engine stalls: watchdog completion, halt, queued job never starts.
    n0 = n_start;
    src_q.push_back(mk(1, 2, 3, 1, 1, 0));
    src_q.push_back(mk(0, 9, TILES, 0, -1, 0));
    n = 0;
    while (!(tmo_cyc != 0 && cyc > tmo_cyc + 5) && n < 2000) begin step(); n++; end
    check_eq("t4_tmo_wait", 32'(n < 2000), 32'd1);
    repeat (100) step();
    check_eq("t4_one_start", 32'(n_start - n0), 32'd1);
    check_eq("t4_busy", 32'(busy), 32'd1);
    check_eq("t4_err", 32'(err), 32'd1);
    check_eq("t4_queued", 32'(pend_q.size()), 32'd1);
    check_eq("t4_cpl_done", 32'(cpl_valid), 32'd0);
    do_reset("t4_reset");
    n0 = n_start;
    repeat (20) step();
    check_eq("t4_fifo_empty", 32'(n_start - n0), 32'd0);

    // Asynchronous reset in the middle of a running job.
    gap_max = 0;
    src_q.push_back(mk(3, 11, TILES, 0, 0, 0));
    n = 0;
    while (tile_cnt != CNT_W'(300) && n < 2000) begin step(); n++; end
    check_eq("t5_reach_300", 32'(tile_cnt), 32'd300);
    #2;
    do_reset("t5_async");

    // Engine pulses while idle are ignored.
    src_q.push_back(mk(0, 12, 7, 0, 0, 0));
    run_drain(500, "t6_drain");
    n0 = n_start; noise_pct = 100;
    repeat (30) step();
    noise_pct = 0;
    check_eq("t6_cnt", 32'(tile_cnt), 32'd7);
    check_eq("t6_no_cpl", 32'(cpl_valid), 32'd0);
    check_eq("t6_no_start", 32'(n_start - n0), 32'd0);

    // Random traffic: mixed counts, back-pressure, idle noise.
    gap_max = 1; rdy_pct = 60; push_pct = 40; noise_pct = 20;
    for (int i = 0; i < 25; i++) begin
      r = int'($urandom_range(9, 0));
      if (r < 3) t = TILES;
      else if (r == 3) t = TILES - 1;
      else if (r == 4) t = TILES + 1;
      else t = int'($urandom_range(40, 0));
      src_q.push_back(mk(int'($urandom_range(3, 0)), int'($urandom_range(15, 0)), t, 0, -1,
                         1'($urandom_range(1, 0))));
    end
    run_drain(60000, "rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
